// File: rtl/easyaxi_rd_slv.sv
// easyaxi_rd_slv -- AXI read responder for the EasyAXI read master bench.
//
// Accepts AR requests into an in-order outstanding queue and returns R bursts
// (FIXED, INCR, WRAP, up to 16 beats). Read data is synthetic: each OKAY beat
// returns its own byte address, so no backing memory is needed. Illegal burst
// encodings return SLVERR on every beat; beats at or above ADDR_LIMIT return
// DECERR.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   axi_slv_ar*           AR channel (valid/ready, id, addr, len, size, burst)
//   axi_slv_r*            R channel (valid/ready, id, data, resp, last)
//   ost_cnt               current AR queue occupancy

`ifndef AXI_ID_W
`define AXI_ID_W 4
`endif
`ifndef AXI_ADDR_W
`define AXI_ADDR_W 32
`endif
`ifndef AXI_DATA_W
`define AXI_DATA_W 64
`endif
`ifndef AXI_LEN_W
`define AXI_LEN_W 8
`endif
`ifndef AXI_SIZE_W
`define AXI_SIZE_W 3
`endif
`ifndef AXI_BURST_W
`define AXI_BURST_W 2
`endif
`ifndef AXI_RESP_W
`define AXI_RESP_W 2
`endif

module easyaxi_rd_slv #(
  parameter int unsigned              OST_DEPTH  = 16,
  parameter logic [`AXI_ADDR_W-1:0]   ADDR_LIMIT = `AXI_ADDR_W'('h1000)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        axi_slv_arvalid,
  output logic                        axi_slv_arready,
  input  logic [`AXI_ID_W-1:0]        axi_slv_arid,
  input  logic [`AXI_ADDR_W-1:0]      axi_slv_araddr,
  input  logic [`AXI_LEN_W-1:0]       axi_slv_arlen,
  input  logic [`AXI_SIZE_W-1:0]      axi_slv_arsize,
  input  logic [`AXI_BURST_W-1:0]     axi_slv_arburst,
  output logic                        axi_slv_rvalid,
  input  logic                        axi_slv_rready,
  output logic [`AXI_ID_W-1:0]        axi_slv_rid,
  output logic [`AXI_DATA_W-1:0]      axi_slv_rdata,
  output logic [`AXI_RESP_W-1:0]      axi_slv_rresp,
  output logic                        axi_slv_rlast,
  output logic [$clog2(OST_DEPTH):0]  ost_cnt
);

  localparam int unsigned IW = `AXI_ID_W;
  localparam int unsigned AW = `AXI_ADDR_W;
  localparam int unsigned DW = `AXI_DATA_W;
  localparam int unsigned LW = `AXI_LEN_W;
  localparam int unsigned SW = `AXI_SIZE_W;
  localparam int unsigned BW = `AXI_BURST_W;
  localparam int unsigned RW = `AXI_RESP_W;
  localparam int unsigned PW = $clog2(OST_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned MaxSize = $clog2(DW / 8);

  localparam logic [BW-1:0] BurstFixed = BW'(0);
  localparam logic [BW-1:0] BurstIncr  = BW'(1);
  localparam logic [BW-1:0] BurstWrap  = BW'(2);
  localparam logic [BW-1:0] BurstRsvd  = BW'(3);

  localparam logic [RW-1:0] RespOkay   = RW'(0);
  localparam logic [RW-1:0] RespSlvErr = RW'(2);
  localparam logic [RW-1:0] RespDecErr = RW'(3);

  typedef enum logic [0:0] {StIdle, StBurst} state_e;

  // AR queue storage and pointers
  logic [IW-1:0] q_id    [OST_DEPTH];
  logic [AW-1:0] q_addr  [OST_DEPTH];
  logic [LW-1:0] q_len   [OST_DEPTH];
  logic [SW-1:0] q_size  [OST_DEPTH];
  logic [BW-1:0] q_burst [OST_DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Working registers of the burst currently being returned
  state_e        state_q, state_d;
  logic [IW-1:0] id_q, id_d;
  logic [AW-1:0] cur_addr_q, cur_addr_d;
  logic [LW-1:0] beats_left_q, beats_left_d;
  logic [SW-1:0] size_q, size_d;
  logic [BW-1:0] mode_q, mode_d;
  logic          err_q, err_d;
  logic [AW-1:0] wrap_base_q, wrap_base_d;
  logic [AW-1:0] wrap_end_q, wrap_end_d;

  logic push, pop, load;
  logic beat_hs, last_hs;

  // Queue head decode
  logic [IW-1:0] h_id;
  logic [AW-1:0] h_addr;
  logic [LW-1:0] h_len;
  logic [SW-1:0] h_size;
  logic [BW-1:0] h_burst;
  logic [AW-1:0] h_bytes;
  logic [AW-1:0] h_total;
  logic          h_wrap_len_ok;
  logic          h_err;

  // Address advance
  logic [AW-1:0] bytes;
  logic [AW-1:0] incr_next;
  logic [AW-1:0] wrap_inc;
  logic [AW-1:0] next_addr;

  logic [RW-1:0] beat_resp;
  logic [DW-1:0] addr_as_data;

  // No full-bypass: a pop in the same cycle does not open arready.
  assign axi_slv_arready = ~rst & (cnt_q < CW'(OST_DEPTH));
  assign push            = axi_slv_arvalid & axi_slv_arready;

  assign axi_slv_rvalid = (state_q == StBurst);
  assign beat_hs        = axi_slv_rvalid & axi_slv_rready;
  assign last_hs        = beat_hs & (beats_left_q == '0);
  assign load           = ((state_q == StIdle) | last_hs) & (cnt_q != '0);
  assign pop            = load;

  assign h_id    = q_id[rd_ptr_q];
  assign h_addr  = q_addr[rd_ptr_q];
  assign h_len   = q_len[rd_ptr_q];
  assign h_size  = q_size[rd_ptr_q];
  assign h_burst = q_burst[rd_ptr_q];

  assign h_bytes       = AW'(1) << h_size;
  assign h_total       = h_bytes * (AW'(h_len) + AW'(1));
  assign h_wrap_len_ok = (h_len == LW'(1)) | (h_len == LW'(3)) |
                         (h_len == LW'(7)) | (h_len == LW'(15));
  assign h_err         = (h_burst == BurstRsvd) |
                         ((h_burst == BurstWrap) & ~h_wrap_len_ok) |
                         (h_size > SW'(MaxSize));

  assign bytes     = AW'(1) << size_q;
  assign incr_next = (cur_addr_q & ~(bytes - AW'(1))) + bytes;
  assign wrap_inc  = cur_addr_q + bytes;

  always_comb begin
    next_addr = incr_next;
    unique case (mode_q)
      BurstFixed: next_addr = cur_addr_q;
      BurstWrap:  next_addr = (wrap_inc == wrap_end_q) ? wrap_base_q : wrap_inc;
      default:    next_addr = incr_next;
    endcase
  end

  // Queue pointer and occupancy update
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // R engine next state
  always_comb begin
    state_d      = state_q;
    id_d         = id_q;
    cur_addr_d   = cur_addr_q;
    beats_left_d = beats_left_q;
    size_d       = size_q;
    mode_d       = mode_q;
    err_d        = err_q;
    wrap_base_d  = wrap_base_q;
    wrap_end_d   = wrap_end_q;

    if (load) begin
      state_d      = StBurst;
      id_d         = h_id;
      cur_addr_d   = h_addr;
      beats_left_d = h_len;
      size_d       = h_size;
      // Error bursts (including illegal-length WRAP) walk the INCR sequence.
      mode_d       = h_err ? BurstIncr : h_burst;
      err_d        = h_err;
      wrap_base_d  = h_addr & ~(h_total - AW'(1));
      wrap_end_d   = (h_addr & ~(h_total - AW'(1))) + h_total;
    end else if (beat_hs) begin
      if (beats_left_q == '0) begin
        state_d = StIdle;
      end else begin
        beats_left_d = beats_left_q - LW'(1);
        cur_addr_d   = next_addr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      state_q      <= StIdle;
      id_q         <= '0;
      cur_addr_q   <= '0;
      beats_left_q <= '0;
      size_q       <= '0;
      mode_q       <= BurstIncr;
      err_q        <= 1'b0;
      wrap_base_q  <= '0;
      wrap_end_q   <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
      state_q      <= state_d;
      id_q         <= id_d;
      cur_addr_q   <= cur_addr_d;
      beats_left_q <= beats_left_d;
      size_q       <= size_d;
      mode_q       <= mode_d;
      err_q        <= err_d;
      wrap_base_q  <= wrap_base_d;
      wrap_end_q   <= wrap_end_d;
    end
  end

  // Queue storage needs no reset: occupancy guards every read.
  always_ff @(posedge clk) begin
    if (push) begin
      q_id[wr_ptr_q]    <= axi_slv_arid;
      q_addr[wr_ptr_q]  <= axi_slv_araddr;
      q_len[wr_ptr_q]   <= axi_slv_arlen;
      q_size[wr_ptr_q]  <= axi_slv_arsize;
      q_burst[wr_ptr_q] <= axi_slv_arburst;
    end
  end

  // Response: SLVERR for the whole burst wins over the per-beat DECERR check.
  always_comb begin
    beat_resp = RespOkay;
    if (err_q) begin
      beat_resp = RespSlvErr;
    end else if (cur_addr_q >= ADDR_LIMIT) begin
      beat_resp = RespDecErr;
    end
  end

  if (DW > AW) begin : g_zext
    assign addr_as_data = {{(DW - AW){1'b0}}, cur_addr_q};
  end else begin : g_trunc
    assign addr_as_data = cur_addr_q[DW-1:0];
  end

  // All R outputs derive from registers only, so they hold while stalled.
  assign axi_slv_rid   = id_q;
  assign axi_slv_rresp = axi_slv_rvalid ? beat_resp : RespOkay;
  assign axi_slv_rdata = (axi_slv_rvalid && (beat_resp == RespOkay)) ? addr_as_data : '0;
  assign axi_slv_rlast = axi_slv_rvalid & (beats_left_q == '0);
  assign ost_cnt       = cnt_q;

endmodule

// File: tb/tb_easyaxi_rd_slv.sv
`ifndef AXI_ID_W
`define AXI_ID_W 4
`endif
`ifndef AXI_ADDR_W
`define AXI_ADDR_W 32
`endif
`ifndef AXI_DATA_W
`define AXI_DATA_W 64
`endif
`ifndef AXI_LEN_W
`define AXI_LEN_W 8
`endif
`ifndef AXI_SIZE_W
`define AXI_SIZE_W 3
`endif
`ifndef AXI_BURST_W
`define AXI_BURST_W 2
`endif
`ifndef AXI_RESP_W
`define AXI_RESP_W 2
`endif

module tb_easyaxi_rd_slv;

  logic                    clk;
  logic                    rst;
  logic                    axi_slv_arvalid;
  logic                    axi_slv_arready;
  logic [`AXI_ID_W-1:0]    axi_slv_arid;
  logic [`AXI_ADDR_W-1:0]  axi_slv_araddr;
  logic [`AXI_LEN_W-1:0]   axi_slv_arlen;
  logic [`AXI_SIZE_W-1:0]  axi_slv_arsize;
  logic [`AXI_BURST_W-1:0] axi_slv_arburst;
  logic                    axi_slv_rvalid;
  logic                    axi_slv_rready;
  logic [`AXI_ID_W-1:0]    axi_slv_rid;
  logic [`AXI_DATA_W-1:0]  axi_slv_rdata;
  logic [`AXI_RESP_W-1:0]  axi_slv_rresp;
  logic                    axi_slv_rlast;
  logic [4:0]              ost_cnt;

  int total = 0;
  int bad   = 0;

  easyaxi_rd_slv #(
    .OST_DEPTH  (16),
    .ADDR_LIMIT (32'h0000_1000)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .axi_slv_arvalid (axi_slv_arvalid),
    .axi_slv_arready (axi_slv_arready),
    .axi_slv_arid    (axi_slv_arid),
    .axi_slv_araddr  (axi_slv_araddr),
    .axi_slv_arlen   (axi_slv_arlen),
    .axi_slv_arsize  (axi_slv_arsize),
    .axi_slv_arburst (axi_slv_arburst),
    .axi_slv_rvalid  (axi_slv_rvalid),
    .axi_slv_rready  (axi_slv_rready),
    .axi_slv_rid     (axi_slv_rid),
    .axi_slv_rdata   (axi_slv_rdata),
    .axi_slv_rresp   (axi_slv_rresp),
    .axi_slv_rlast   (axi_slv_rlast),
    .ost_cnt         (ost_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Presents one AR and returns #1 after the edge that handshakes it.
  task automatic send_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    int n;
    axi_slv_arvalid = 1'b1;
    axi_slv_arid    = id;
    axi_slv_araddr  = addr;
    axi_slv_arlen   = len;
    axi_slv_arsize  = size;
    axi_slv_arburst = burst;
    #1;
    n = 0;
    while (axi_slv_arready !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) begin
      total++; bad++;
      $display("FAIL ar_timeout id=%0d arready=%b want 1", id, axi_slv_arready);
    end
    @(posedge clk); #1;
    axi_slv_arvalid = 1'b0;
  endtask

  task automatic wait_rvalid(output bit ok);
    int n;
    n = 0;
    while (axi_slv_rvalid !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    ok = (axi_slv_rvalid === 1'b1);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    axi_slv_arvalid = 1'b0;
    axi_slv_rready  = 1'b0;
    axi_slv_arid = '0; axi_slv_araddr = '0; axi_slv_arlen = '0;
    axi_slv_arsize = '0; axi_slv_arburst = '0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (axi_slv_rvalid !== 1'b0 || axi_slv_rlast !== 1'b0 || axi_slv_rid !== 4'd0 ||
        axi_slv_rdata !== 64'd0 || axi_slv_rresp !== 2'd0) begin
      bad++;
      $display("FAIL reset_r got v=%b l=%b id=%0h d=%0h r=%0d want all 0", axi_slv_rvalid,
               axi_slv_rlast, axi_slv_rid, axi_slv_rdata, axi_slv_rresp);
    end
    total++;
    if (ost_cnt !== 5'd0) begin
      bad++; $display("FAIL reset_ost_cnt got %0d want 0", ost_cnt);
    end
    total++;
    if (axi_slv_arready !== 1'b0) begin
      bad++; $display("FAIL reset_arready_in_rst got %b want 0", axi_slv_arready);
    end
    rst = 1'b0;
    #1;
    total++;
    if (axi_slv_arready !== 1'b1) begin
      bad++; $display("FAIL reset_arready_after got %b want 1", axi_slv_arready);
    end
  endtask

  task automatic test_incr();
    logic [63:0] expd;
    axi_slv_rready = 1'b1;
    send_ar(4'd2, 32'h10, 8'd3, 3'd2, 2'd1);
    total++;
    if (axi_slv_rvalid !== 1'b0 || ost_cnt !== 5'd1) begin
      bad++; $display("FAIL incr_t1 rvalid=%b ost_cnt=%0d want 0/1", axi_slv_rvalid, ost_cnt);
    end
    @(posedge clk); #1;
    total++;
    if (axi_slv_rvalid !== 1'b1) begin
      bad++; $display("FAIL incr_latency rvalid=%b want 1 at T+2", axi_slv_rvalid);
    end
    for (int k = 0; k < 4; k++) begin
      expd = 64'h10 + 64'(4 * k);
      total++;
      if (axi_slv_rvalid !== 1'b1 || axi_slv_rdata !== expd || axi_slv_rlast !== (k == 3) ||
          axi_slv_rid !== 4'd2 || axi_slv_rresp !== 2'd0) begin
        bad++;
        $display("FAIL incr_beat%0d got v=%b d=%0h l=%b id=%0d r=%0d want 1/%0h/%b/2/0", k,
                 axi_slv_rvalid, axi_slv_rdata, axi_slv_rlast, axi_slv_rid, axi_slv_rresp,
                 expd, (k == 3));
      end
      @(posedge clk); #1;
    end
    total++;
    if (axi_slv_rvalid !== 1'b0) begin
      bad++; $display("FAIL incr_end rvalid=%b want 0", axi_slv_rvalid);
    end
  endtask

  task automatic test_wrap_fixed();
    logic [63:0] wrap_exp [4];
    bit ok;
    wrap_exp[0] = 64'h34; wrap_exp[1] = 64'h38; wrap_exp[2] = 64'h3C; wrap_exp[3] = 64'h30;
    axi_slv_rready = 1'b1;
    send_ar(4'd3, 32'h34, 8'd3, 3'd2, 2'd2);
    wait_rvalid(ok);
    total++;
    if (!ok) begin
      bad++; $display("FAIL wrap_wait rvalid=%b want 1", axi_slv_rvalid);
    end
    for (int k = 0; k < 4; k++) begin
      total++;
      if (axi_slv_rvalid !== 1'b1 || axi_slv_rdata !== wrap_exp[k] ||
          axi_slv_rlast !== (k == 3) || axi_slv_rid !== 4'd3 || axi_slv_rresp !== 2'd0) begin
        bad++;
        $display("FAIL wrap_beat%0d got v=%b d=%0h l=%b id=%0d r=%0d want 1/%0h/%b/3/0", k,
                 axi_slv_rvalid, axi_slv_rdata, axi_slv_rlast, axi_slv_rid, axi_slv_rresp,
                 wrap_exp[k], (k == 3));
      end
      @(posedge clk); #1;
    end
    send_ar(4'd4, 32'h30, 8'd3, 3'd2, 2'd0);
    wait_rvalid(ok);
    total++;
    if (!ok) begin
      bad++; $display("FAIL fixed_wait rvalid=%b want 1", axi_slv_rvalid);
    end
    for (int k = 0; k < 4; k++) begin
      total++;
      if (axi_slv_rvalid !== 1'b1 || axi_slv_rdata !== 64'h30 || axi_slv_rlast !== (k == 3) ||
          axi_slv_rid !== 4'd4 || axi_slv_rresp !== 2'd0) begin
        bad++;
        $display("FAIL fixed_beat%0d got v=%b d=%0h l=%b id=%0d r=%0d want 1/30/%b/4/0", k,
                 axi_slv_rvalid, axi_slv_rdata, axi_slv_rlast, axi_slv_rid, axi_slv_rresp,
                 (k == 3));
      end
      @(posedge clk); #1;
    end
    total++;
    if (axi_slv_rvalid !== 1'b0) begin
      bad++; $display("FAIL fixed_end rvalid=%b want 0", axi_slv_rvalid);
    end
  endtask

  task automatic test_errors();
    logic [31:0] c_addr  [4];
    logic [7:0]  c_len   [4];
    logic [2:0]  c_size  [4];
    logic [1:0]  c_burst [4];
    logic [1:0]  er;
    logic [63:0] ed;
    bit ok;
    // case 0: DECERR past limit; 1: reserved burst; 2: WRAP len=2; 3: size wider than bus
    c_addr[0] = 32'hFF8; c_len[0] = 8'd3; c_size[0] = 3'd2; c_burst[0] = 2'd1;
    c_addr[1] = 32'h40;  c_len[1] = 8'd3; c_size[1] = 3'd2; c_burst[1] = 2'd3;
    c_addr[2] = 32'h40;  c_len[2] = 8'd2; c_size[2] = 3'd2; c_burst[2] = 2'd2;
    c_addr[3] = 32'h40;  c_len[3] = 8'd0; c_size[3] = 3'd4; c_burst[3] = 2'd1;
    axi_slv_rready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      send_ar(4'(8 + c), c_addr[c], c_len[c], c_size[c], c_burst[c]);
      wait_rvalid(ok);
      total++;
      if (!ok) begin
        bad++; $display("FAIL err%0d_wait rvalid=%b want 1", c, axi_slv_rvalid);
      end
      for (int k = 0; k <= int'(c_len[c]); k++) begin
        if (c == 0) begin
          er = (k >= 2) ? 2'd3 : 2'd0;
          ed = (k >= 2) ? 64'd0 : 64'hFF8 + 64'(4 * k);
        end else begin
          er = 2'd2;
          ed = 64'd0;
        end
        total++;
        if (axi_slv_rvalid !== 1'b1 || axi_slv_rresp !== er || axi_slv_rdata !== ed ||
            axi_slv_rlast !== (k == int'(c_len[c])) || axi_slv_rid !== 4'(8 + c)) begin
          bad++;
          $display("FAIL err%0d_beat%0d got v=%b r=%0d d=%0h l=%b id=%0d want 1/%0d/%0h/%b/%0d",
                   c, k, axi_slv_rvalid, axi_slv_rresp, axi_slv_rdata, axi_slv_rlast,
                   axi_slv_rid, er, ed, (k == int'(c_len[c])), 8 + c);
        end
        @(posedge clk); #1;
      end
      total++;
      if (axi_slv_rvalid !== 1'b0) begin
        bad++; $display("FAIL err%0d_end rvalid=%b want 0", c, axi_slv_rvalid);
      end
    end
  endtask

  task automatic test_backpressure();
    int beat;
    int cyc;
    bit ok;
    logic [63:0] expd;
    axi_slv_rready = 1'b0;
    send_ar(4'd7, 32'h100, 8'd15, 3'd2, 2'd1);
    wait_rvalid(ok);
    total++;
    if (!ok) begin
      bad++; $display("FAIL bp_wait rvalid=%b want 1", axi_slv_rvalid);
    end
    beat = 0;
    cyc  = 0;
    while (beat < 16 && cyc < 300) begin
      expd = 64'h100 + 64'(4 * beat);
      total++;
      if (axi_slv_rvalid !== 1'b1 || axi_slv_rdata !== expd || axi_slv_rlast !== (beat == 15) ||
          axi_slv_rid !== 4'd7 || axi_slv_rresp !== 2'd0) begin
        bad++;
        $display("FAIL bp_beat%0d cyc%0d got v=%b d=%0h l=%b id=%0d r=%0d want 1/%0h/%b/7/0",
                 beat, cyc, axi_slv_rvalid, axi_slv_rdata, axi_slv_rlast, axi_slv_rid,
                 axi_slv_rresp, expd, (beat == 15));
      end
      // Guaranteed stalls early on, random afterwards.
      if (cyc < 3) axi_slv_rready = 1'b0;
      else if (cyc == 3) axi_slv_rready = 1'b1;
      else axi_slv_rready = 1'($urandom_range(0, 1));
      if (axi_slv_rready) beat++;
      @(posedge clk); #1;
      cyc++;
    end
    total++;
    if (beat != 16) begin
      bad++; $display("FAIL bp_beats got %0d want 16", beat);
    end
    axi_slv_rready = 1'b1;
    total++;
    if (axi_slv_rvalid !== 1'b0) begin
      bad++; $display("FAIL bp_end rvalid=%b want 0", axi_slv_rvalid);
    end
  endtask

  task automatic test_fill_drain();
    int i;
    bit hs;
    logic [63:0] expd;
    axi_slv_rready  = 1'b0;
    i = 0;
    axi_slv_arvalid = 1'b1;
    axi_slv_arid    = 4'(i % 16);
    axi_slv_araddr  = 32'h200 + 32'(i * 16);
    axi_slv_arlen   = 8'(i % 4);
    axi_slv_arsize  = 3'd2;
    axi_slv_arburst = 2'd1;
    #1;
    repeat (40) begin
      hs = (axi_slv_arready === 1'b1);
      @(posedge clk); #1;
      if (hs) begin
        i++;
        axi_slv_arid   = 4'(i % 16);
        axi_slv_araddr = 32'h200 + 32'(i * 16);
        axi_slv_arlen  = 8'(i % 4);
      end
    end
    axi_slv_arvalid = 1'b0;
    #1;
    total++;
    if (i != 17) begin
      bad++; $display("FAIL fill_handshakes got %0d want 17", i);
    end
    total++;
    if (axi_slv_arready !== 1'b0 || ost_cnt !== 5'd16) begin
      bad++; $display("FAIL fill_full arready=%b ost_cnt=%0d want 0/16", axi_slv_arready, ost_cnt);
    end
    axi_slv_rready = 1'b1;
    for (int b = 0; b < 17; b++) begin
      for (int k = 0; k <= b % 4; k++) begin
        expd = 64'h200 + 64'(b * 16) + 64'(4 * k);
        total++;
        if (axi_slv_rvalid !== 1'b1 || axi_slv_rid !== 4'(b % 16) || axi_slv_rdata !== expd ||
            axi_slv_rlast !== (k == b % 4) || axi_slv_rresp !== 2'd0) begin
          bad++;
          $display("FAIL drain_b%0d_k%0d got v=%b id=%0d d=%0h l=%b r=%0d want 1/%0d/%0h/%b/0",
                   b, k, axi_slv_rvalid, axi_slv_rid, axi_slv_rdata, axi_slv_rlast,
                   axi_slv_rresp, b % 16, expd, (k == b % 4));
        end
        @(posedge clk); #1;
        if (b == 0 && k == 0) begin
          total++;
          if (axi_slv_arready !== 1'b1) begin
            bad++; $display("FAIL drain_arready_after_pop got %b want 1", axi_slv_arready);
          end
        end
      end
    end
    total++;
    if (axi_slv_rvalid !== 1'b0 || ost_cnt !== 5'd0) begin
      bad++;
      $display("FAIL drain_end rvalid=%b ost_cnt=%0d want 0/0", axi_slv_rvalid, ost_cnt);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    axi_slv_rready = 1'b0;
    send_ar(4'd1, 32'h400, 8'd3, 3'd2, 2'd1);
    send_ar(4'd2, 32'h500, 8'd3, 3'd2, 2'd1);
    send_ar(4'd3, 32'h600, 8'd3, 3'd2, 2'd1);
    total++;
    if (axi_slv_rvalid !== 1'b1 || ost_cnt !== 5'd2) begin
      bad++;
      $display("FAIL rstmid_pre rvalid=%b ost_cnt=%0d want 1/2", axi_slv_rvalid, ost_cnt);
    end
    axi_slv_rready = 1'b1;
    @(posedge clk); #1;
    total++;
    if (axi_slv_rdata !== 64'h404) begin
      bad++; $display("FAIL rstmid_beat2 got %0h want 404", axi_slv_rdata);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    total++;
    if (axi_slv_rvalid !== 1'b0 || ost_cnt !== 5'd0 || axi_slv_arready !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_flush rvalid=%b ost_cnt=%0d arready=%b want 0/0/0",
               axi_slv_rvalid, ost_cnt, axi_slv_arready);
    end
    rst = 1'b0;
    #1;
    total++;
    if (axi_slv_arready !== 1'b1) begin
      bad++; $display("FAIL rstmid_arready got %b want 1", axi_slv_arready);
    end
    send_ar(4'd5, 32'h80, 8'd1, 3'd2, 2'd1);
    total++;
    if (axi_slv_rvalid !== 1'b0) begin
      bad++; $display("FAIL rstmid_stale rvalid=%b want 0", axi_slv_rvalid);
    end
    wait_rvalid(ok);
    for (int k = 0; k < 2; k++) begin
      total++;
      if (axi_slv_rvalid !== 1'b1 || axi_slv_rid !== 4'd5 ||
          axi_slv_rdata !== 64'h80 + 64'(4 * k) || axi_slv_rlast !== (k == 1) ||
          axi_slv_rresp !== 2'd0) begin
        bad++;
        $display("FAIL rstmid_beat%0d got v=%b id=%0d d=%0h l=%b r=%0d want 1/5/%0h/%b/0", k,
                 axi_slv_rvalid, axi_slv_rid, axi_slv_rdata, axi_slv_rlast, axi_slv_rresp,
                 64'h80 + 64'(4 * k), (k == 1));
      end
      @(posedge clk); #1;
    end
    total++;
    if (axi_slv_rvalid !== 1'b0 || ost_cnt !== 5'd0) begin
      bad++;
      $display("FAIL rstmid_end rvalid=%b ost_cnt=%0d want 0/0", axi_slv_rvalid, ost_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_incr();
    test_wrap_fixed();
    test_errors();
    test_backpressure();
    test_fill_drain();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
